seq_calc: RTL and testbench

Parametrised, multi-cycle integer calculator. It supports add, subtract, multiply and divide on WIDTH-bit unsigned operands.
- Add/sub complete in one cycle.
- Multiply uses an iterative shift-add datapath; divide uses an iterative restoring datapath. Neither uses a combinational array.
- Sits behind a valid/ready operand interface and drives a valid/ready result interface. Used wherever a compact, width-scalable arithmetic unit is needed.

---
 rtl/calc_pkg.sv | 29 ++
 rtl/seq_calc_if.sv | 26 ++
 rtl/calc_iter_unit.sv | 66 ++++++
 rtl/seq_calc.sv | 128 ++++++++++++
 tb/tb_seq_calc.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared types for the sequential calculator: opcode and FSM state encodings,
// plus the iterative-unit mode select.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } iter_mode_e;

  // Divide by zero short-circuits to DONE, so only real divides iterate.
  function automatic logic is_iterative(input op_e op, input logic b_zero);
    return (op == OP_MUL) || ((op == OP_DIV) && !b_zero);
  endfunction

endpackage

// File: rtl/seq_calc_if.sv
// Operand/result handshake bundle for seq_calc; slave is the calculator side.
interface seq_calc_if #(
  parameter int WIDTH = 8
) ();

  logic               in_valid;
  logic               in_ready;
  logic [1:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic               flag;

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flag
  );

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flag
  );

endinterface

// File: rtl/calc_iter_unit.sv
// Shared shift-add multiplier / restoring divider, one bit per cycle.
// The 2*WIDTH register holds {partial product, multiplier} or {remainder, quotient}.
module calc_iter_unit
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  iter_mode_e         mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] acc_nxt
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0]   cnt;
  iter_mode_e         mode_q;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    acc_nxt   = acc;
    if (mode_q == MODE_MUL) begin
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    end else if (div_diff[WIDTH]) begin
      // Trial subtract went negative: restore and shift in a 0 quotient bit.
      acc_nxt = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  // High during the cycle that performs the last iteration.
  assign done = (cnt == CNT_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      mode_q <= MODE_MUL;
      opnd   <= '0;
      acc    <= '0;
    end else if (start) begin
      cnt    <= CNT_LOAD;
      mode_q <= mode;
      opnd   <= (mode == MODE_DIV) ? b : a;
      acc    <= {{WIDTH{1'b0}}, ((mode == MODE_DIV) ? a : b)};
    end else if (cnt != '0) begin
      cnt    <= cnt - CNT_ONE;
      acc    <= acc_nxt;
    end
  end

endmodule

// File: rtl/seq_calc.sv
// Multi-cycle unsigned calculator: add/sub in one cycle, mul/div via calc_iter_unit.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operation
// MUL   | shift-add multiply iterating
// DIV   | restoring divide iterating
// DONE  | result held with out_valid until consumed
module seq_calc
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  seq_calc_if.slave  bus,
  output logic       busy
);

  state_e             state;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [2*WIDTH-1:0] result_q;
  logic               flag_q;

  op_e                op_in;
  logic               b_zero;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic               iter_start;
  iter_mode_e         iter_mode;
  logic               iter_done;
  logic [2*WIDTH-1:0] iter_acc_nxt;

  assign op_in      = op_e'(bus.op);
  assign b_zero     = (bus.b == '0);
  assign add_sum    = {1'b0, bus.a} + {1'b0, bus.b};
  assign sub_diff   = {1'b0, bus.a} - {1'b0, bus.b};
  assign iter_start = (state == IDLE) && bus.in_valid && is_iterative(op_in, b_zero);
  assign iter_mode  = (op_in == OP_DIV) ? MODE_DIV : MODE_MUL;

  calc_iter_unit #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (iter_start),
    .mode    (iter_mode),
    .a       (bus.a),
    .b       (bus.b),
    .done    (iter_done),
    .acc_nxt (iter_acc_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flag_q      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            busy       <= 1'b1;
            case (op_in)
              OP_ADD: begin
                result_q    <= {{(WIDTH-1){1'b0}}, add_sum};
                flag_q      <= add_sum[WIDTH];
                out_valid_q <= 1'b1;
                state       <= DONE;
              end
              OP_SUB: begin
                result_q    <= {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]};
                flag_q      <= sub_diff[WIDTH];
                out_valid_q <= 1'b1;
                state       <= DONE;
              end
              OP_MUL: state <= MUL;
              OP_DIV: begin
                if (b_zero) begin
                  // Remainder = dividend, quotient saturates to all ones.
                  result_q    <= {bus.a, {WIDTH{1'b1}}};
                  flag_q      <= 1'b1;
                  out_valid_q <= 1'b1;
                  state       <= DONE;
                end else begin
                  state <= DIV;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
        MUL, DIV: begin
          if (iter_done) begin
            result_q    <= iter_acc_nxt;
            flag_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flag      = flag_q;

endmodule

// File: tb/tb_seq_calc.sv
// Self-checking bench for seq_calc: WIDTH=8 directed cases and a WIDTH=16 random
// regression, both compared every cycle against an arithmetic reference model.
module tb_seq_calc;
  import calc_pkg::*;

  logic clk;
  logic rst_n;

  seq_calc_if #(.WIDTH(8))  if8 ();
  seq_calc_if #(.WIDTH(16)) if16 ();
  logic busy8, busy16;

  seq_calc #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8),  .busy(busy8));
  seq_calc #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16), .busy(busy16));

  // Index 0 drives/observes the 8-bit instance, index 1 the 16-bit one.
  logic        in_valid_d[2];
  logic [1:0]  op_d[2];
  logic [15:0] a_d[2];
  logic [15:0] b_d[2];
  logic        out_ready_d[2];

  logic        o_valid[2];
  logic        o_rdy[2];
  logic        o_flag[2];
  logic        o_busy[2];
  logic [63:0] o_res[2];

  assign if8.in_valid   = in_valid_d[0];
  assign if8.op         = op_d[0];
  assign if8.a          = a_d[0][7:0];
  assign if8.b          = b_d[0][7:0];
  assign if8.out_ready  = out_ready_d[0];
  assign if16.in_valid  = in_valid_d[1];
  assign if16.op        = op_d[1];
  assign if16.a         = a_d[1];
  assign if16.b         = b_d[1];
  assign if16.out_ready = out_ready_d[1];

  assign o_valid[0] = if8.out_valid;
  assign o_valid[1] = if16.out_valid;
  assign o_rdy[0]   = if8.in_ready;
  assign o_rdy[1]   = if16.in_ready;
  assign o_flag[0]  = if8.flag;
  assign o_flag[1]  = if16.flag;
  assign o_busy[0]  = busy8;
  assign o_busy[1]  = busy16;
  assign o_res[0]   = {48'b0, if8.result};
  assign o_res[1]   = {32'b0, if16.result};

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  bit              st_busy[2];
  int              acc_cyc[2];
  int              elat[2];
  longint unsigned eres[2];
  logic            eflag[2];
  int              n_acc[2];
  int              n_xfer[2];
  bit              seen_ov[2];
  logic [63:0]     obs_res[2];
  logic            obs_flag[2];
  int              obs_lat[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int u, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (w%0d) at cycle %0d: got 0x%0h, expected 0x%0h", nm, (u == 0) ? 8 : 16, cyc, act, exp);
    end
  endtask

  // Reference arithmetic straight from the operation definitions.
  function automatic void model(input int w, input logic [1:0] o, input longint unsigned x,
                                input longint unsigned y, output longint unsigned r,
                                output logic f, output int lat);
    longint unsigned m;
    m   = (64'd1 << w) - 64'd1;
    lat = w + 1;
    f   = 1'b0;
    r   = 0;
    case (o)
      2'd0: begin r = x + y; f = ((x + y) >> w) != 0; lat = 1; end
      2'd1: begin r = (x - y) & m; f = (x < y); lat = 1; end
      2'd2: r = x * y;
      default: begin
        if (y == 0) begin
          r = (x << w) | m; f = 1'b1; lat = 1;
        end else begin
          r = ((x % y) << w) | (x / y);
        end
      end
    endcase
  endfunction

  always @(negedge clk) begin
    cyc++;
    for (int u = 0; u < 2; u++) begin
      int              w;
      bit              ov_exp;
      longint unsigned x, y, m;
      w = (u == 0) ? 8 : 16;
      if (!rst_n) begin
        chk("rst_in_ready",  u, 64'(o_rdy[u]),   64'd1);
        chk("rst_out_valid", u, 64'(o_valid[u]), 64'd0);
        chk("rst_busy",      u, 64'(o_busy[u]),  64'd0);
        chk("rst_result",    u, o_res[u],        64'd0);
        chk("rst_flag",      u, 64'(o_flag[u]),  64'd0);
        st_busy[u] = 1'b0;
      end else begin
        ov_exp = st_busy[u] && (cyc >= acc_cyc[u] + elat[u]);
        chk("busy",      u, 64'(o_busy[u]),  64'(st_busy[u]));
        chk("in_ready",  u, 64'(o_rdy[u]),   64'(!st_busy[u]));
        chk("out_valid", u, 64'(o_valid[u]), 64'(ov_exp));
        if (ov_exp) begin
          chk("result", u, o_res[u],        eres[u]);
          chk("flag",   u, 64'(o_flag[u]),  64'(eflag[u]));
        end
        if (st_busy[u] && o_valid[u] === 1'b1 && !seen_ov[u]) begin
          seen_ov[u] = 1'b1;
          obs_lat[u] = cyc - acc_cyc[u];
        end
        if (!st_busy[u] && in_valid_d[u]) begin
          m = (64'd1 << w) - 64'd1;
          x = 64'(a_d[u]) & m;
          y = 64'(b_d[u]) & m;
          model(w, op_d[u], x, y, eres[u], eflag[u], elat[u]);
          st_busy[u] = 1'b1;
          acc_cyc[u] = cyc;
          seen_ov[u] = 1'b0;
          obs_lat[u] = -1;
          n_acc[u]++;
        end else if (ov_exp && out_ready_d[u]) begin
          st_busy[u]  = 1'b0;
          obs_res[u]  = o_res[u];
          obs_flag[u] = o_flag[u];
          n_xfer[u]++;
        end
      end
    end
  end

  // Issue one operation; with hold>0, keep out_ready low for that many valid
  // cycles while presenting a second (to-be-ignored) operation.
  task automatic do_op(input int u, input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                       input int hold, output logic [63:0] r, output logic f, output int l);
    int acc0, xf0, vcnt, t;
    acc0 = n_acc[u];
    xf0  = n_xfer[u];
    @(posedge clk); #1;
    in_valid_d[u]  = 1'b1;
    op_d[u]        = o;
    a_d[u]         = x;
    b_d[u]         = y;
    out_ready_d[u] = 1'b0;
    t = 0;
    while (n_acc[u] == acc0 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("accept_wait", u, 64'(n_acc[u] - acc0), 64'd1);
    in_valid_d[u] = (hold > 0);
    op_d[u]       = ~o;
    a_d[u]        = ~x;
    b_d[u]        = ~y;
    vcnt = 0;
    t    = 0;
    while (n_xfer[u] == xf0 && t < 60) begin
      if (o_valid[u] === 1'b1) vcnt++;
      if (vcnt > hold) begin
        out_ready_d[u] = 1'b1;
        in_valid_d[u]  = 1'b0;
      end
      @(posedge clk); #1;
      t++;
    end
    chk("transfer_wait", u, 64'(n_xfer[u] - xf0), 64'd1);
    out_ready_d[u] = 1'b0;
    in_valid_d[u]  = 1'b0;
    r = obs_res[u];
    f = obs_flag[u];
    l = obs_lat[u];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] r;
    logic        f;
    int          l;
    int          acc_before, xf_before;
    logic [31:0] rx, ry;
    logic [1:0]  ro;

    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      in_valid_d[u] = 1'b0; op_d[u] = 2'd0; a_d[u] = '0; b_d[u] = '0; out_ready_d[u] = 1'b0;
      st_busy[u] = 1'b0; n_acc[u] = 0; n_xfer[u] = 0; acc_cyc[u] = 0; elat[u] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    do_op(0, OP_ADD, 16'd200, 16'd100, 0, r, f, l);
    chk("add_res", 0, r, 64'h012C); chk("add_flag", 0, 64'(f), 64'd1); chk("add_lat", 0, 64'(l), 64'd1);
    do_op(0, OP_SUB, 16'd5, 16'd7, 0, r, f, l);
    chk("sub_res", 0, r, 64'h00FE); chk("sub_flag", 0, 64'(f), 64'd1); chk("sub_lat", 0, 64'(l), 64'd1);
    do_op(0, OP_MUL, 16'd255, 16'd255, 0, r, f, l);
    chk("mul_res", 0, r, 64'hFE01); chk("mul_flag", 0, 64'(f), 64'd0); chk("mul_lat", 0, 64'(l), 64'd9);
    do_op(0, OP_MUL, 16'd0, 16'd77, 0, r, f, l);
    chk("mul0_res", 0, r, 64'h0); chk("mul0_lat", 0, 64'(l), 64'd9);
    do_op(0, OP_DIV, 16'd200, 16'd7, 0, r, f, l);
    chk("div_res", 0, r, 64'h041C); chk("div_flag", 0, 64'(f), 64'd0); chk("div_lat", 0, 64'(l), 64'd9);
    do_op(0, OP_DIV, 16'd42, 16'd0, 0, r, f, l);
    chk("div0_res", 0, r, 64'h2AFF); chk("div0_flag", 0, 64'(f), 64'd1); chk("div0_lat", 0, 64'(l), 64'd1);

    acc_before = n_acc[0];
    xf_before  = n_xfer[0];
    do_op(0, OP_MUL, 16'd13, 16'd11, 5, r, f, l);
    chk("bp_res", 0, r, 64'h008F);
    chk("bp_ready_after", 0, 64'(o_rdy[0]), 64'd1);
    chk("bp_single_accept", 0, 64'(n_acc[0] - acc_before), 64'd1);
    chk("bp_single_xfer", 0, 64'(n_xfer[0] - xf_before), 64'd1);

    // Abort a divide mid-iteration with an asynchronous reset.
    @(posedge clk); #1;
    in_valid_d[0] = 1'b1; op_d[0] = OP_DIV; a_d[0] = 16'd200; b_d[0] = 16'd7;
    acc_before = n_acc[0];
    for (int t = 0; t < 20 && n_acc[0] == acc_before; t++) begin
      @(posedge clk); #1;
    end
    chk("rst_div_accept", 0, 64'(n_acc[0] - acc_before), 64'd1);
    in_valid_d[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_in_ready",  0, 64'(o_rdy[0]),   64'd1);
    chk("async_out_valid", 0, 64'(o_valid[0]), 64'd0);
    chk("async_busy",      0, 64'(o_busy[0]),  64'd0);
    chk("async_result",    0, o_res[0],        64'd0);
    chk("async_flag",      0, 64'(o_flag[0]),  64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    xf_before = n_xfer[0];
    repeat (15) @(posedge clk);
    chk("rst_no_result", 0, 64'(n_xfer[0] - xf_before), 64'd0);
    do_op(0, OP_ADD, 16'd1, 16'd2, 0, r, f, l);
    chk("post_rst_add", 0, r, 64'h3);

    do_op(1, OP_ADD, 16'hFFFF, 16'h0001, 0, r, f, l);
    chk("w16_add_res", 1, r, 64'h10000); chk("w16_add_flag", 1, 64'(f), 64'd1);
    do_op(1, OP_SUB, 16'hFFFF, 16'h0001, 0, r, f, l);
    chk("w16_sub_res", 1, r, 64'hFFFE); chk("w16_sub_flag", 1, 64'(f), 64'd0);
    do_op(1, OP_MUL, 16'hFFFF, 16'h0001, 0, r, f, l);
    chk("w16_mul_res", 1, r, 64'hFFFF); chk("w16_mul_lat", 1, 64'(l), 64'd17);
    do_op(1, OP_DIV, 16'hFFFF, 16'h0001, 0, r, f, l);
    chk("w16_div_res", 1, r, 64'h0000FFFF); chk("w16_div_flag", 1, 64'(f), 64'd0);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      do_op(1, ro, rx[15:0], ry[15:0], $urandom_range(0, 2), r, f, l);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
